// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the 5-stage RV32I pipeline
//                hazard controller: forwarding select encoding, sequencer
//                states and the memory-wait counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // EX operand source select driven onto the ALU / branch-unit muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register-file read value
        FWD_WB  = 2'b01,   // value being written back in WB
        FWD_MEM = 2'b10    // ALU result held in MEM
    } fwd_sel_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    // Width of the consecutive memory-wait counter (saturating).
    localparam int c_WAIT_CNT_W = 8;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller. The datapath (master) supplies register-address
//                and control taps from the pipeline registers; the controller
//                (slave) returns stage enables/flushes, operand forwarding
//                selects, the memory-timeout flag and performance counters.
//  Ports       : none (signal bundle only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_controller_if #(
    parameter int REG_ADDR_W = 5
);
    // Taps from the pipeline registers
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_RUWr;
    logic                  ex_DMRd;
    logic                  ex_NextPCSrc;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_RUWr;
    logic                  mem_dm_access;
    logic                  dm_ready;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_RUWr;

    // Controls back to the datapath
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        dm_error;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_RUWr, ex_DMRd, ex_NextPCSrc,
        output mem_rd, mem_RUWr, mem_dm_access, dm_ready,
        output wb_rd, wb_RUWr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  fwd_a, fwd_b, dm_error,
        input  stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_RUWr, ex_DMRd, ex_NextPCSrc,
        input  mem_rd, mem_RUWr, mem_dm_access, dm_ready,
        input  wb_rd, wb_RUWr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output fwd_a, fwd_b, dm_error,
        output stall_cnt, flush_cnt, wait_cnt
    );

endinterface : hazard_controller_if
`default_nettype wire

// File: rtl/hazard_controller_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Forwarding comparator for one EX source operand. MEM wins
//                over WB because it holds the younger result; x0 is never
//                forwarded since it always reads as zero.
//  Ports       : ex_rs            - EX source register
//                mem_rd/mem_RUWr  - MEM destination and write enable
//                wb_rd/wb_RUWr    - WB destination and write enable
//                sel              - operand source select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic [REG_ADDR_W-1:0] ex_rs,
    input  wire logic [REG_ADDR_W-1:0] mem_rd,
    input  wire logic                  mem_RUWr,
    input  wire logic [REG_ADDR_W-1:0] wb_rd,
    input  wire logic                  wb_RUWr,
    output fwd_sel_e                   sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_RUWr && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            sel = FWD_MEM;
        end else if (wb_RUWr && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            sel = FWD_WB;
        end
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline sequencer for the 5-stage RV32I datapath. Produces
//                PC / pipeline-register enables and flushes, EX operand
//                forwarding selects, and freezes the front of the pipe while
//                data memory is busy. A memory access that stays busy for
//                MEM_TIMEOUT wait cycles parks the controller in ERROR until
//                reset.
//  Ports       : clk, rst - clock and synchronous active-high reset
//                hz       - hazard_controller_if.slave bundle (taps in,
//                           enables/flushes/forwarding/counters out)
//  Config      : HAZARD_PERF_CNT_EN - builds the stall/flush/wait
//                performance counters; otherwise they read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16   // legal range 1..255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_controller_if.slave hz
);

    localparam logic [c_WAIT_CNT_W-1:0] c_TIMEOUT  = c_WAIT_CNT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_ONE = c_WAIT_CNT_W'(1);

    hz_state_e               r_state;
    logic [c_WAIT_CNT_W-1:0] r_wait_cnt;

    fwd_sel_e w_fwd_a;
    fwd_sel_e w_fwd_b;
    logic     w_active;
    logic     w_mem_stall;
    logic     w_load_hit;
    logic     w_branch;
    logic     w_load_use;

    // ---------------------------------------------------------------- forwarding
    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_rs    (hz.ex_rs1),
        .mem_rd   (hz.mem_rd),
        .mem_RUWr (hz.mem_RUWr),
        .wb_rd    (hz.wb_rd),
        .wb_RUWr  (hz.wb_RUWr),
        .sel      (w_fwd_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_rs    (hz.ex_rs2),
        .mem_rd   (hz.mem_rd),
        .mem_RUWr (hz.mem_RUWr),
        .wb_rd    (hz.wb_rd),
        .wb_RUWr  (hz.wb_RUWr),
        .sel      (w_fwd_b)
    );

    // ------------------------------------------------------------ hazard detect
    assign w_active = (r_state != ERROR);

    // Once waiting, only dm_ready releases the freeze; the access qualifier
    // matters only for starting a wait.
    assign w_mem_stall = ((r_state == RUN) && hz.mem_dm_access && !hz.dm_ready) ||
                         ((r_state == MEM_WAIT) && !hz.dm_ready);

    assign w_load_hit = hz.ex_DMRd && hz.ex_RUWr && (hz.ex_rd != '0) &&
                        ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                         (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    // A taken branch squashes the instruction in ID, so a load-use hit on it
    // is moot.
    assign w_branch   = w_active && !w_mem_stall && hz.ex_NextPCSrc;
    assign w_load_use = w_active && !w_mem_stall && !hz.ex_NextPCSrc && w_load_hit;

    // ------------------------------------------------------------ control out
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.id_ex_en     = 1'b1;
        hz.ex_mem_en    = 1'b1;
        hz.mem_wb_en    = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.mem_wb_flush = 1'b0;
        if (rst) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.mem_wb_en    = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.mem_wb_flush = 1'b1;
        end else if (!w_active) begin
            hz.pc_en     = 1'b0;
            hz.if_id_en  = 1'b0;
            hz.id_ex_en  = 1'b0;
            hz.ex_mem_en = 1'b0;
            hz.mem_wb_en = 1'b0;
        end else if (w_mem_stall) begin
            // Freeze IF..MEM; WB keeps loading a bubble so the stalled
            // access is not retired twice.
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.mem_wb_flush = 1'b1;
        end else if (w_branch) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    assign hz.fwd_a    = rst ? FWD_RF : w_fwd_a;
    assign hz.fwd_b    = rst ? FWD_RF : w_fwd_b;
    assign hz.dm_error = !rst && (r_state == ERROR);

    // ------------------------------------------------------------ sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= c_WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (hz.dm_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state <= ERROR;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                    end
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ perf counters
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_wait_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_wait_perf <= '0;
        end else begin
            if (w_load_use) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_branch) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (r_state == MEM_WAIT) begin
                r_wait_perf <= r_wait_perf + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
    assign hz.wait_cnt  = r_wait_perf;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
    assign hz.wait_cnt  = 32'd0;
`endif

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Self-checking bench for hazard_controller. A stimulus process
//                applies directed scenarios followed by random cycles and
//                pushes the reference model's expected outputs into a queue;
//                a monitor pops and compares every cycle.
//  Config      : HAZARD_PERF_CNT_EN - expects live performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam int c_RAW       = 5;
    localparam int c_TIMEOUT   = 4;
    localparam int c_RAND_CYC  = 2000;

    typedef struct {
        logic           rst;
        logic [c_RAW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
        logic           id_use_rs1, id_use_rs2;
        logic           ex_RUWr, ex_DMRd, ex_NextPCSrc;
        logic           mem_RUWr, mem_dm_access, dm_ready, wb_RUWr;
    } stim_t;

    // ctrl packs {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id, id_ex, mem_wb flushes}
    typedef struct {
        int          cyc;
        logic [7:0]  ctrl;
        logic [7:0]  mask;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        err;
        logic        chk_cnt;
        logic [31:0] sc;
        logic [31:0] fc;
        logic [31:0] wc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_controller_if #(.REG_ADDR_W(c_RAW)) hz ();

    hazard_controller #(
        .REG_ADDR_W  (c_RAW),
        .MEM_TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic stim_done = 1'b0;

    // Reference model state, in terms of observable behaviour
    logic        m_err;      // timed out, frozen until reset
    int          m_miss;     // consecutive cycles the current access has been busy
    logic        m_known;    // counters meaningful (after first reset)
    logic [31:0] m_sc, m_fc, m_wc;

    function automatic logic [1:0] ref_fwd(input logic [c_RAW-1:0] rs,
                                           input logic [c_RAW-1:0] mrd, input logic mw,
                                           input logic [c_RAW-1:0] wrd, input logic ww);
        if (mw && mrd != 0 && mrd == rs) return 2'b10;
        if (ww && wrd != 0 && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.dm_ready = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        logic busy, lu;
        @(posedge clk);
        #1;
        cyc++;
        rst              = s.rst;
        hz.id_rs1        = s.id_rs1;
        hz.id_rs2        = s.id_rs2;
        hz.id_use_rs1    = s.id_use_rs1;
        hz.id_use_rs2    = s.id_use_rs2;
        hz.ex_rs1        = s.ex_rs1;
        hz.ex_rs2        = s.ex_rs2;
        hz.ex_rd         = s.ex_rd;
        hz.ex_RUWr       = s.ex_RUWr;
        hz.ex_DMRd       = s.ex_DMRd;
        hz.ex_NextPCSrc  = s.ex_NextPCSrc;
        hz.mem_rd        = s.mem_rd;
        hz.mem_RUWr      = s.mem_RUWr;
        hz.mem_dm_access = s.mem_dm_access;
        hz.dm_ready      = s.dm_ready;
        hz.wb_rd         = s.wb_rd;
        hz.wb_RUWr       = s.wb_RUWr;

        busy = !s.dm_ready && (m_miss > 0 || s.mem_dm_access);
        lu   = s.ex_DMRd && s.ex_RUWr && s.ex_rd != 0 &&
               ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));

        e.cyc  = cyc;
        e.mask = 8'hFF;
        e.fa   = s.rst ? 2'b00 : ref_fwd(s.ex_rs1, s.mem_rd, s.mem_RUWr, s.wb_rd, s.wb_RUWr);
        e.fb   = s.rst ? 2'b00 : ref_fwd(s.ex_rs2, s.mem_rd, s.mem_RUWr, s.wb_rd, s.wb_RUWr);
        e.err  = !s.rst && m_err;
        if (s.rst)                e.ctrl = 8'b00000_111;
        else if (m_err)           e.ctrl = 8'b00000_000;
        else if (busy) begin      e.ctrl = 8'b00000_001; e.mask = 8'b11110_001; end
        else if (s.ex_NextPCSrc)  e.ctrl = 8'b11111_110;
        else if (lu)              e.ctrl = 8'b00111_010;
        else                      e.ctrl = 8'b11111_000;
        e.chk_cnt = m_known;
        e.sc = m_sc;
        e.fc = m_fc;
        e.wc = m_wc;
        exp_q.push_back(e);

        // Advance the model across the coming clock edge
        if (s.rst) begin
            m_err = 0; m_miss = 0; m_known = 1;
            m_sc = 0; m_fc = 0; m_wc = 0;
        end else if (!m_err) begin
`ifdef HAZARD_PERF_CNT_EN
            if (m_miss > 0) m_wc = m_wc + 32'd1;
`endif
            if (busy) begin
                m_miss++;
                // entry cycle plus MEM_TIMEOUT wait cycles without completion
                if (m_miss == c_TIMEOUT + 1) m_err = 1;
            end else begin
                m_miss = 0;
`ifdef HAZARD_PERF_CNT_EN
                if (s.ex_NextPCSrc) m_fc = m_fc + 32'd1;
                else if (lu)        m_sc = m_sc + 32'd1;
`endif
            end
        end
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Monitor: outputs are settled mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ctrl", e.cyc,
                      32'({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en, hz.mem_wb_en,
                           hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_flush} & e.mask),
                      32'(e.ctrl & e.mask));
                check("fwd_a", e.cyc, 32'(hz.fwd_a), 32'(e.fa));
                check("fwd_b", e.cyc, 32'(hz.fwd_b), 32'(e.fb));
                check("dm_error", e.cyc, 32'(hz.dm_error), 32'(e.err));
                if (e.chk_cnt) begin
                    check("stall_cnt", e.cyc, hz.stall_cnt, e.sc);
                    check("flush_cnt", e.cyc, hz.flush_cnt, e.fc);
                    check("wait_cnt",  e.cyc, hz.wait_cnt,  e.wc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        m_err = 0; m_miss = 0;
`ifdef HAZARD_PERF_CNT_EN
        m_known = 0;
`else
        m_known = 1;
`endif
        m_sc = 0; m_fc = 0; m_wc = 0;
        s = idle(); s.rst = 1;
        rst = 1'b1;
        drive(s);
        drive(s);

        // Load-use bubble, then WB forwarding resolves it
        s = idle(); s.ex_DMRd = 1; s.ex_RUWr = 1; s.ex_rd = 5; s.id_use_rs1 = 1; s.id_rs1 = 5;
        drive(s);
        s = idle(); s.wb_rd = 5; s.wb_RUWr = 1; s.ex_rs1 = 5;
        drive(s);

        // Forward priority MEM over WB, and x0 never forwarded
        s = idle(); s.mem_rd = 7; s.wb_rd = 7; s.ex_rs2 = 7; s.mem_RUWr = 1; s.wb_RUWr = 1;
        drive(s);
        s.mem_rd = 0; s.ex_rs2 = 0; s.wb_rd = 0;
        drive(s);

        // Branch overriding a load-use hit
        s = idle(); s.ex_DMRd = 1; s.ex_RUWr = 1; s.ex_rd = 3; s.id_use_rs2 = 1; s.id_rs2 = 3;
        s.ex_NextPCSrc = 1;
        drive(s);

        // Memory wait: three busy cycles then completion
        s = idle(); s.mem_dm_access = 1; s.dm_ready = 0;
        repeat (3) drive(s);
        s.dm_ready = 1;
        drive(s);
        drive(idle());

        // Timeout into ERROR, held until reset
        s = idle(); s.mem_dm_access = 1; s.dm_ready = 0;
        repeat (8) drive(s);
        s = idle(); s.ex_NextPCSrc = 1;
        drive(s);
        s = idle(); s.rst = 1;
        drive(s);
        drive(idle());

        // Reset pulse in the middle of a wait
        s = idle(); s.mem_dm_access = 1; s.dm_ready = 0;
        repeat (2) drive(s);
        s.rst = 1;
        drive(s);
        drive(idle());
        drive(idle());

        // Random traffic on a small register set to provoke hits
        for (int i = 0; i < c_RAND_CYC; i++) begin
            s.rst           = ($urandom_range(0, 99) < 2);
            s.id_rs1        = c_RAW'($urandom_range(0, 3));
            s.id_rs2        = c_RAW'($urandom_range(0, 3));
            s.ex_rs1        = c_RAW'($urandom_range(0, 3));
            s.ex_rs2        = c_RAW'($urandom_range(0, 3));
            s.ex_rd         = c_RAW'($urandom_range(0, 3));
            s.mem_rd        = c_RAW'($urandom_range(0, 3));
            s.wb_rd         = c_RAW'($urandom_range(0, 3));
            s.id_use_rs1    = 1'($urandom_range(0, 1));
            s.id_use_rs2    = 1'($urandom_range(0, 1));
            s.ex_RUWr       = 1'($urandom_range(0, 1));
            s.ex_DMRd       = 1'($urandom_range(0, 1));
            s.ex_NextPCSrc  = ($urandom_range(0, 99) < 15);
            s.mem_RUWr      = 1'($urandom_range(0, 1));
            s.wb_RUWr       = 1'($urandom_range(0, 1));
            s.mem_dm_access = ($urandom_range(0, 99) < 25);
            s.dm_ready      = ($urandom_range(0, 99) < 60);
            drive(s);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_controller
`default_nettype wire

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage (IF/ID/EX/MEM/WB) version of the RV32I datapath.
- Each cycle it decides the following for the PC and the four pipeline registers:
  - stage enables and flushes;
  - EX operand forwarding selects;
  - freezing the pipeline while data memory is not ready.
- Sits beside the datapath. Inputs are register-address and control fields tapped from the pipeline registers. Outputs go straight to PC and pipeline-register enable/clear pins and to the ALU/branch-unit operand muxes.

Parameters:
- REG_ADDR_W, 5: register-file address width.
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before error; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  REG_ADDR_W  source registers of the instruction in EX.
- ex_rd  in  REG_ADDR_W  destination register of EX.
- ex_RUWr  in  1  EX writes the register file.
- ex_DMRd  in  1  EX instruction is a load.
- ex_NextPCSrc  in  1  branch/jump taken, resolved in EX.
- mem_rd  in  REG_ADDR_W  destination register of MEM.
- mem_RUWr  in  1  MEM writes the register file.
- mem_dm_access  in  1  MEM is a load or store.
- dm_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  REG_ADDR_W  destination register of WB.
- wb_RUWr  in  1  WB writes the register file.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  synchronous clear (bubble) of that register.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 WB value, 10 MEM ALURes.
- dm_error  out  1  sticky memory timeout flag.
- stall_cnt, flush_cnt, wait_cnt  out  32 each  performance counters.

Behaviour:
- Reset: rst is synchronous and active-high.
  - While rst=1: all *_en=0, all *_flush=1, fwd_a=fwd_b=00, dm_error=0.
  - FSM state becomes RUN; the wait counter and the perf counters are cleared.
  - A reset asserted mid-MEM_WAIT or in ERROR takes effect on the next rising edge, with no residue.
- FSM states: RUN, MEM_WAIT, ERROR. State is registered; all outputs are combinational from state plus inputs.
- Forwarding (all states, combinational, identical rule for fwd_a/ex_rs1 and fwd_b/ex_rs2):
  - 10 if mem_RUWr && mem_rd!=0 && mem_rd==ex_rs1.
  - else 01 if wb_RUWr && wb_rd!=0 && wb_rd==ex_rs1.
  - else 00.
  - MEM has priority over WB; x0 is never forwarded.
- RUN, with priority evaluated in this order:
  1. Memory stall, when mem_dm_access && !dm_ready:
     - pc_en, if_id_en, id_ex_en, ex_mem_en are 0; mem_wb_flush=1.
     - The wait counter loads 1 and the next state is MEM_WAIT.
  2. Taken branch, when ex_NextPCSrc=1:
     - all enables are 1; if_id_flush=1 and id_ex_flush=1.
     - Penalty is 2 bubbles. This overrides a load-use hit in the same cycle.
  3. Load-use, when ex_DMRd && ex_RUWr && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
     - pc_en=0, if_id_en=0, id_ex_flush=1; the other enables are 1.
     - Exactly one bubble. The following cycle resolves via WB forwarding (01).
  4. Otherwise: all enables are 1 and all flushes are 0.
- MEM_WAIT:
  - Outputs are as in the RUN memory-stall case.
  - If dm_ready=1: all enables are 1 and no flush; next state is RUN. Branch and load-use are evaluated this same cycle with RUN rules.
  - Else if the wait counter == MEM_TIMEOUT: next state is ERROR.
  - Else the wait counter increments.
- ERROR:
  - All enables are 0 and all flushes are 0; dm_error=1.
  - The state is held until rst.
- Counter widths:
  - The wait counter is 8 bits and saturates.
  - The perf counters are 32 bits and wrap modulo 2^32.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- With the macro defined, each counter increments once per cycle under its condition:
  - stall_cnt on each load-use bubble cycle;
  - flush_cnt on each taken-branch flush cycle;
  - wait_cnt on each cycle in MEM_WAIT.
  - All counters are cleared by rst.
- Without the macro: the ports remain and are tied to 32'd0, and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - enum fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10};
  - enum hz_state_e {RUN, MEM_WAIT, ERROR};
  - the wait-counter width constant.
- Sub-module fwd_sel: combinational comparator for one operand (ex_rs, mem_rd/RUWr, wb_rd/RUWr -> fwd_sel_e). It is instantiated twice, for A and for B.

Test Plan:
- Load-use:
  - Stimulus: ex_DMRd=1, ex_RUWr=1, ex_rd=5, id_use_rs1=1, id_rs1=5.
  - Required: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1.
  - Next cycle, with wb_rd=5 and ex_rs1=5: fwd_a=01.
- Forward priority:
  - Stimulus: mem_rd=wb_rd=ex_rs2=7, both RUWr=1.
  - Required: fwd_b=10.
  - With mem_rd=0 and ex_rs2=0: fwd_b=00.
- Branch plus load-use in the same cycle:
  - Stimulus: ex_NextPCSrc=1 with a load-use hit.
  - Required: pc_en=1, if_id_flush=1, id_ex_flush=1, no stall.
- Memory wait:
  - Stimulus: mem_dm_access=1, dm_ready=0 for 3 cycles, then 1.
  - Required: the front 4 enables are 0 for 3 cycles, mem_wb_flush=1; release on the 4th cycle; wait_cnt=3 when HAZARD_PERF_CNT_EN is defined.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, dm_ready held 0.
  - Required: dm_error=1 from the 5th cycle after entry; all enables 0 thereafter.
- Reset mid-MEM_WAIT:
  - Stimulus: pulse rst for 1 cycle during MEM_WAIT.
  - Required: next cycle is RUN, dm_error=0, counters 0, flushes deasserted.
